// File: rtl/knn_vote_pkg.sv
// -----------------------------------------------------------------------------
// knn_vote_pkg
// Shared definitions for the KNN vote reader:
//   - FSM state encoding (2 bits, exported on the debug port)
//   - class_w_f(): width of a class index for a given class count
//   - DEF_N_CLASS: default number of legal class labels
// -----------------------------------------------------------------------------
package knn_vote_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SCAN  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

    localparam int DEF_N_CLASS = 8;

    // Smallest w with 2**w >= n (minimum 1). Bounded loop keeps it
    // usable as a constant function in parameter defaults.
    function automatic int class_w_f(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/knn_vote_reader_if.sv
// -----------------------------------------------------------------------------
// knn_vote_reader_if
// Bundles the sorter read port and the result handshake of the vote reader.
//   sel        : read address to the sorter (W/2)
//   data_in    : sorter DATA_OUT, valid one cycle after sel changes (W/2)
//   res_valid  : result available
//   res_ready  : consumer accepts the result
//   res_class  : winning class (CLASS_W)
//   res_votes  : votes of the winning class (W/2)
//   res_err    : at least one scanned label was out of range
//
// Handshake: res_valid rises once the result is final and stays high, with
// res_class/res_votes/res_err held stable, until a clock edge samples
// res_valid & res_ready; that edge completes the transfer and drops
// res_valid. res_ready may be asserted at any time and is only meaningful
// while res_valid is high.
//
// Modports: master = vote reader side, slave = sorter/register-block side.
// -----------------------------------------------------------------------------
interface knn_vote_reader_if
    import knn_vote_pkg::*;
#(
    parameter int W       = 32,
    parameter int CLASS_W = class_w_f(DEF_N_CLASS)
);
    logic [W/2-1:0]     sel;
    logic [W/2-1:0]     data_in;
    logic               res_valid;
    logic               res_ready;
    logic [CLASS_W-1:0] res_class;
    logic [W/2-1:0]     res_votes;
    logic               res_err;

    modport master (
        output sel,
        input  data_in,
        output res_valid,
        input  res_ready,
        output res_class,
        output res_votes,
        output res_err
    );

    modport slave (
        input  sel,
        output data_in,
        input  res_valid,
        output res_ready,
        input  res_class,
        input  res_votes,
        input  res_err
    );

endinterface

// File: rtl/knn_vote_counter.sv
// -----------------------------------------------------------------------------
// knn_vote_counter
// Per-class vote counter bank with running best-class tracking.
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : clear all counters, best and err (start of a vote)
//   inc        : label is a valid read this cycle; count it
//   label      : raw sorter word (W/2); low CLASS_W bits are the class
//   best_class : class that first reached the current maximum
//   best_cnt   : current maximum vote count
//   err        : a label >= N_CLASS was seen since the last clear
// -----------------------------------------------------------------------------
module knn_vote_counter
    import knn_vote_pkg::*;
#(
    parameter int W       = 32,
    parameter int N_CLASS = DEF_N_CLASS,
    parameter int CLASS_W = class_w_f(N_CLASS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [W/2-1:0]     label,
    output logic [CLASS_W-1:0] best_class,
    output logic [W/2-1:0]     best_cnt,
    output logic               err
);

    localparam int HW = W / 2;
    localparam logic [HW-1:0] N_CLASS_V = HW'(N_CLASS);

    logic [HW-1:0]      cnt_q [N_CLASS];
    logic [HW-1:0]      cnt_d [N_CLASS];
    logic [CLASS_W-1:0] best_class_q, best_class_d;
    logic [HW-1:0]      best_cnt_q, best_cnt_d;
    logic               err_q, err_d;

    logic [CLASS_W-1:0] lab;
    logic               lab_ok;
    logic [HW-1:0]      new_cnt;

    // The whole word is range-checked, not just the low bits, so a word like
    // 0x0105 is rejected even though its low bits look like a legal class.
    assign lab    = label[CLASS_W-1:0];
    assign lab_ok = (label < N_CLASS_V);

    always_comb begin
        new_cnt      = '0;
        cnt_d        = cnt_q;
        best_class_d = best_class_q;
        best_cnt_d   = best_cnt_q;
        err_d        = err_q;
        if (clr) begin
            for (int i = 0; i < N_CLASS; i++) begin
                cnt_d[i] = '0;
            end
            best_class_d = '0;
            best_cnt_d   = '0;
            err_d        = 1'b0;
        end else if (inc) begin
            if (!lab_ok) begin
                err_d = 1'b1;
            end else begin
                new_cnt    = cnt_q[lab] + HW'(1);
                cnt_d[lab] = new_cnt;
                // Strict '>' keeps the class that reached the maximum first.
                if (new_cnt > best_cnt_q) begin
                    best_class_d = lab;
                    best_cnt_d   = new_cnt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CLASS; i++) begin
                cnt_q[i] <= '0;
            end
            best_class_q <= '0;
            best_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < N_CLASS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            best_class_q <= best_class_d;
            best_cnt_q   <= best_cnt_d;
            err_q        <= err_d;
        end
    end

    assign best_class = best_class_q;
    assign best_cnt   = best_cnt_q;
    assign err        = err_q;

endmodule

// File: rtl/knn_vote_reader.sv
// -----------------------------------------------------------------------------
// knn_vote_reader
// Walks the KNN sorter read port over the K nearest entries, counts the
// class label found in each, and presents the majority class.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : one-cycle request; accepted only in IDLE
//   k_eff     : populated neighbour count, sampled with start, clamped to HW_K
//   busy      : high from the cycle after start until the result handshake
//   state_dbg : current FSM state (IDLE/SCAN/DRAIN/HOLD)
//   bus       : sorter read port + result handshake (master side)
// -----------------------------------------------------------------------------
module knn_vote_reader
    import knn_vote_pkg::*;
#(
    parameter int W       = 32,
    parameter int HW_K    = 10,
    parameter int N_CLASS = DEF_N_CLASS,
    parameter int CLASS_W = class_w_f(N_CLASS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W/2-1:0] k_eff,
    output logic           busy,
    output state_t         state_dbg,
    knn_vote_reader_if.master bus
);

    localparam int HW = W / 2;
    localparam logic [HW-1:0] HW_K_V = HW'(HW_K);

    state_t        state_q, state_d;
    logic [HW-1:0] sel_q, sel_d;
    logic [HW-1:0] kq_q, kq_d;
    logic          rd_valid_q, rd_valid_d;
    logic          res_valid_q, res_valid_d;
    logic          clr;
    logic [HW-1:0] k_clamped;

    logic [CLASS_W-1:0] best_class;
    logic [HW-1:0]      best_cnt;
    logic               err;

    assign k_clamped = (k_eff > HW_K_V) ? HW_K_V : k_eff;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        kq_d        = kq_q;
        res_valid_d = res_valid_q;
        clr         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr   = 1'b1;
                    kq_d  = k_clamped;
                    sel_d = '0;
                    state_d = (k_clamped == '0) ? ST_HOLD : ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Last address stays on the port through DRAIN.
                if (sel_q + HW'(1) == kq_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    sel_d = sel_q + HW'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_HOLD;
                sel_d   = '0;
            end
            ST_HOLD: begin
                // The first HOLD cycle only raises res_valid, so the result
                // is presented one edge after the last count has settled.
                if (res_valid_q && bus.res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // data_in lags sel by one cycle: a word is countable in the cycle after
    // its address was driven in SCAN.
    assign rd_valid_d = (state_q == ST_SCAN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            kq_q        <= '0;
            rd_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            kq_q        <= kq_d;
            rd_valid_q  <= rd_valid_d;
            res_valid_q <= res_valid_d;
        end
    end

    knn_vote_counter #(
        .W       (W),
        .N_CLASS (N_CLASS),
        .CLASS_W (CLASS_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .inc        (rd_valid_q),
        .label      (bus.data_in),
        .best_class (best_class),
        .best_cnt   (best_cnt),
        .err        (err)
    );

    assign busy          = (state_q != ST_IDLE);
    assign state_dbg     = state_q;
    assign bus.sel       = sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_class = best_class;
    assign bus.res_votes = best_cnt;
    assign bus.res_err   = err;

endmodule
